// File: rtl/pe_cpout_ser.sv
// Buffers PECPOUT result vectors in a small circular store and serialises them
// lane by lane (lane 0 first) onto a registered 64-bit valid/ready stream.
module pe_cpout_ser #(
  parameter int LANES = 8,
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [LANES-1:0][WIDTH-1:0]  PECPOUT,
  input  logic                         Q_VALID,
  output logic [WIDTH-1:0]             DOUT,
  output logic                         DOUT_VALID,
  input  logic                         DOUT_READY,
  output logic                         DOUT_LAST,
  output logic                         OVERFLOW,
  output logic                         BUSY
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [LANES-1:0][WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic [LW-1:0]               r_lane;
  logic [WIDTH-1:0]            r_dout;
  logic                        r_overflow;

  logic                        w_xfer;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_push;
  logic                        w_drop;
  logic [CW-1:0]               w_count_after_pop;
  logic                        w_load;
  logic [PW-1:0]               w_rd_addr;
  logic [LW-1:0]               w_rd_lane;
  logic [PW-1:0]               w_rd_ptr_next;
  logic [LW-1:0]               w_lane_next;
  logic [WIDTH-1:0]            w_rd_data;

  assign w_xfer = (r_state == S_SEND) && DOUT_READY;
  assign w_pop  = w_xfer && (r_lane == LAST_LANE);
  assign w_full = (r_count == FULL);
  // A pop of the final lane frees the head slot in the same edge, so a push
  // arriving while full can reuse it instead of being dropped.
  assign w_push = Q_VALID && (!w_full || w_pop);
  assign w_drop = Q_VALID && w_full && !w_pop;
  assign w_count_after_pop = r_count - CW'(w_pop);

  assign w_rd_data = r_mem[w_rd_addr][w_rd_lane];

  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_rd_addr     = r_rd_ptr;
    w_rd_lane     = '0;
    w_rd_ptr_next = r_rd_ptr;
    w_lane_next   = r_lane;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load       = 1'b1;
          w_lane_next  = '0;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          if (r_lane != LAST_LANE) begin
            w_load      = 1'b1;
            w_lane_next = r_lane + LW'(1);
            w_rd_lane   = r_lane + LW'(1);
          end else begin
            // Chain straight into the next entry so streams have no bubbles.
            w_rd_ptr_next = r_rd_ptr + PW'(1);
            w_rd_addr     = r_rd_ptr + PW'(1);
            w_lane_next   = '0;
            if (w_count_after_pop != '0) begin
              w_load = 1'b1;
            end else begin
              w_state_next = S_IDLE;
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && w_push) begin
      r_mem[r_wr_ptr] <= PECPOUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lane     <= '0;
      r_dout     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      r_lane   <= w_lane_next;
      if (w_load) begin
        r_dout <= w_rd_data;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = (r_state == S_SEND);
  assign DOUT_LAST  = (r_state == S_SEND) && (r_lane == LAST_LANE);
  assign OVERFLOW   = r_overflow;
  assign BUSY       = (r_count != '0) || DOUT_VALID;

endmodule

// File: tb/tb_pe_cpout_ser.sv
// Directed bench for pe_cpout_ser: a vector-queue model checks every cycle,
// directed scenarios pin beat order, timing and flags with literal values.
module tb_pe_cpout_ser;

  localparam int LANES = 8;
  localparam int WIDTH = 64;
  localparam int DEPTH = 2;

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             Q_VALID = 1'b0;
  logic             DOUT_READY = 1'b0;
  vec_t             PECPOUT = '0;
  logic [WIDTH-1:0] DOUT;
  logic             DOUT_VALID;
  logic             DOUT_LAST;
  logic             OVERFLOW;
  logic             BUSY;

  always #5 CLK = ~CLK;

  pe_cpout_ser #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PECPOUT    (PECPOUT),
    .Q_VALID    (Q_VALID),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .DOUT_LAST  (DOUT_LAST),
    .OVERFLOW   (OVERFLOW),
    .BUSY       (BUSY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Model: expected beat stream ({last, data}) plus count of held vectors.
  logic [64:0]  exp_q[$];
  int           m_count = 0;
  bit           m_ovf = 1'b0;
  bit           primed = 1'b0;
  bit           rst_pend = 1'b0;
  bit           stall_pend = 1'b0;
  logic [63:0]  stall_dout;
  logic         stall_last;

  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (primed) begin
        if (rst_pend) begin
          chk("rst_dout", DOUT, 64'h0);
          chk("rst_valid", 64'(DOUT_VALID), 64'h0);
          chk("rst_last", 64'(DOUT_LAST), 64'h0);
          chk("rst_busy", 64'(BUSY), 64'h0);
        end
        if (stall_pend) begin
          chk("hold_valid", 64'(DOUT_VALID), 64'h1);
          chk("hold_dout", DOUT, stall_dout);
          chk("hold_last", 64'(DOUT_LAST), 64'(stall_last));
        end
        chk("overflow", 64'(OVERFLOW), 64'(m_ovf));
        chk("busy", 64'(BUSY), 64'((m_count != 0) || DOUT_VALID));
        if (DOUT_VALID) chk("valid_needs_vector", 64'(m_count != 0), 64'h1);
      end
      rst_pend   = 1'b0;
      stall_pend = 1'b0;
      if (!RST) begin
        exp_q.delete();
        m_count  = 0;
        m_ovf    = 1'b0;
        primed   = 1'b1;
        rst_pend = 1'b1;
      end else if (primed) begin
        bit          pop;
        logic [64:0] e;
        pop = 1'b0;
        if (DOUT_VALID && DOUT_READY) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_beat: got beat %h, required none", DOUT);
          end else begin
            e = exp_q.pop_front();
            chk("beat_dout", DOUT, e[63:0]);
            chk("beat_last", 64'(DOUT_LAST), 64'(e[64]));
            pop = e[64];
          end
        end
        if (DOUT_VALID && !DOUT_READY) begin
          stall_pend = 1'b1;
          stall_dout = DOUT;
          stall_last = DOUT_LAST;
        end
        if (Q_VALID) begin
          if (m_count < DEPTH || pop) begin
            m_count++;
            for (int l = 0; l < LANES; l++) exp_q.push_back({(l == LANES - 1), PECPOUT[l]});
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (pop) m_count--;
      end
    end
  endtask

  // Directed scenario machinery: pulses scheduled by cycle index.
  vec_t        pv[3];
  int          pc[3];
  int          np;
  logic [63:0] got_d[$];
  bit          got_l[$];
  int          got_c[$];
  bit          ovf_h[$];
  bit          busy_h[$];

  logic [63:0] a_lanes [LANES] = '{64'h1111_1111, 64'h2222_2222, 64'h3333_3333, 64'h4444_4444,
                                   64'h5555_5555, 64'h1234_1234, 64'h5678_5678, 64'h1234_5678};
  vec_t va, vb, vc, vd;

  function automatic vec_t mk(input logic [63:0] base);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = base + 64'(i) * 64'h0000_0001_0000_0001;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    Q_VALID = 1'b0;
    DOUT_READY = 1'b0;
    step();
    step();
    RST = 1'b1;
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 ready from cycle ron.
  task automatic run_seq(input int ncyc, input int rmode, input int ron, input int rst_at);
    got_d.delete(); got_l.delete(); got_c.delete(); ovf_h.delete(); busy_h.delete();
    for (int k = 0; k < ncyc; k++) begin
      Q_VALID = 1'b0;
      for (int p = 0; p < np; p++) begin
        if (pc[p] == k) begin
          Q_VALID = 1'b1;
          PECPOUT = pv[p];
        end
      end
      case (rmode)
        0:       DOUT_READY = 1'b1;
        1:       DOUT_READY = (k % 3 == 0);
        default: DOUT_READY = (k >= ron);
      endcase
      RST = (k != rst_at);
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk("midrst_dout", DOUT, 64'h0);
        chk("midrst_valid", 64'(DOUT_VALID), 64'h0);
        chk("midrst_last", 64'(DOUT_LAST), 64'h0);
        chk("midrst_busy", 64'(BUSY), 64'h0);
      end
      ovf_h.push_back(OVERFLOW);
      busy_h.push_back(BUSY);
      if (RST && DOUT_VALID && DOUT_READY) begin
        got_d.push_back(DOUT);
        got_l.push_back(DOUT_LAST);
        got_c.push_back(k);
      end
      step();
    end
    Q_VALID = 1'b0;
    RST = 1'b1;
  endtask

  task automatic stimulus();
    for (int i = 0; i < LANES; i++) va[i] = a_lanes[i];
    vb = mk(64'hBBBB_0000_0000_0000);
    vc = mk(64'hCCCC_0000_0000_0000);
    vd = mk(64'hDDDD_0000_0000_0000);

    do_reset();
    chk("reset_dout", DOUT, 64'h0);
    chk("reset_valid", 64'(DOUT_VALID), 64'h0);
    chk("reset_overflow", 64'(OVERFLOW), 64'h0);
    chk("reset_busy", 64'(BUSY), 64'h0);

    // Single vector, ready high
    np = 1; pc[0] = 0; pv[0] = va;
    run_seq(20, 0, 0, -1);
    chk("single_beats", 64'(got_d.size()), 64'd8);
    if (got_d.size() == 8) begin
      for (int i = 0; i < LANES; i++) chk("single_lane", got_d[i], a_lanes[i]);
      chk("single_first_cycle", 64'(got_c[0]), 64'd2);
      chk("single_last_cycle", 64'(got_c[7]), 64'd9);
      chk("single_last_flag", 64'(got_l[7]), 64'h1);
      chk("single_nonlast_flag", 64'(got_l[6]), 64'h0);
    end
    chk("single_busy_during", 64'(busy_h[9]), 64'h1);
    chk("single_busy_after", 64'(busy_h[10]), 64'h0);
    chk("single_overflow", 64'(OVERFLOW), 64'h0);

    // Backpressure with ready 1,0,0 pattern
    do_reset();
    np = 1; pc[0] = 0; pv[0] = va;
    run_seq(40, 1, 0, -1);
    chk("bp_beats", 64'(got_d.size()), 64'd8);
    if (got_d.size() == 8) begin
      for (int i = 0; i < LANES; i++) chk("bp_lane", got_d[i], a_lanes[i]);
      chk("bp_last_cycle", 64'(got_c[7]), 64'd24);
    end

    // Back-to-back vectors eight cycles apart
    do_reset();
    np = 2; pc[0] = 0; pv[0] = va; pc[1] = 8; pv[1] = vb;
    run_seq(30, 0, 0, -1);
    chk("b2b_beats", 64'(got_d.size()), 64'd16);
    if (got_d.size() == 16) begin
      chk("b2b_span", 64'(got_c[15] - got_c[0]), 64'd15);
      chk("b2b_a7", got_d[7], 64'h1234_5678);
      chk("b2b_b0", got_d[8], 64'hBBBB_0000_0000_0000);
      chk("b2b_b7", got_d[15], 64'hBBBB_0007_0000_0007);
      chk("b2b_last8", 64'(got_l[7]), 64'h1);
      chk("b2b_last16", 64'(got_l[15]), 64'h1);
    end

    // Overflow: three pulses into a stalled two-entry buffer
    do_reset();
    np = 3; pc[0] = 0; pv[0] = va; pc[1] = 2; pv[1] = vb; pc[2] = 4; pv[2] = vc;
    run_seq(40, 2, 8, -1);
    chk("ovf_before", 64'(ovf_h[4]), 64'h0);
    chk("ovf_after", 64'(ovf_h[5]), 64'h1);
    chk("ovf_sticky", 64'(OVERFLOW), 64'h1);
    chk("ovf_beats", 64'(got_d.size()), 64'd16);
    if (got_d.size() == 16) begin
      chk("ovf_a0", got_d[0], 64'h1111_1111);
      chk("ovf_b0", got_d[8], 64'hBBBB_0000_0000_0000);
      chk("ovf_b7", got_d[15], 64'hBBBB_0007_0000_0007);
    end

    // Full buffer, push coincides with last-lane pop
    do_reset();
    np = 3; pc[0] = 0; pv[0] = va; pc[1] = 1; pv[1] = vb; pc[2] = 9; pv[2] = vc;
    run_seq(40, 0, 0, -1);
    chk("fullpop_overflow", 64'(OVERFLOW), 64'h0);
    chk("fullpop_beats", 64'(got_d.size()), 64'd24);
    if (got_d.size() == 24) begin
      chk("fullpop_span", 64'(got_c[23] - got_c[0]), 64'd23);
      chk("fullpop_b0", got_d[8], 64'hBBBB_0000_0000_0000);
      chk("fullpop_c0", got_d[16], 64'hCCCC_0000_0000_0000);
      chk("fullpop_c7", got_d[23], 64'hCCCC_0007_0000_0007);
      chk("fullpop_last24", 64'(got_l[23]), 64'h1);
    end

    // Reset on the third beat, then a fresh vector
    do_reset();
    np = 2; pc[0] = 0; pv[0] = va; pc[1] = 7; pv[1] = vd;
    run_seq(25, 0, 0, 4);
    chk("midrst_beats", 64'(got_d.size()), 64'd10);
    if (got_d.size() == 10) begin
      chk("midrst_a1", got_d[1], 64'h2222_2222);
      chk("midrst_a1_last", 64'(got_l[1]), 64'h0);
      chk("midrst_d0", got_d[2], 64'hDDDD_0000_0000_0000);
      chk("midrst_d0_cycle", 64'(got_c[2]), 64'd9);
      chk("midrst_d7", got_d[9], 64'hDDDD_0007_0000_0007);
      chk("midrst_d7_last", 64'(got_l[9]), 64'h1);
    end
    step();
    step();
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_cpout_ser.md
Name: pe_cpout_ser

Overview:
- Downstream stage of pe_cp32bit.
- Captures each 8-lane x 64-bit PECPOUT vector qualified by Q_VALID into a 2-entry vector buffer.
- Serialises the buffered vectors lane by lane onto a 64-bit valid/ready stream (lane 0 first), toward the host DMA path.
- Reports dropped vectors through a sticky overflow flag.

Parameters:
- LANES, 8, number of 64-bit lanes per vector.
- WIDTH, 64, lane width in bits.
- DEPTH, 2, vector buffer entries; must be a power of two, >= 2.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset; synchronous, active-low (0 = reset).
- PECPOUT  input  [LANES-1:0][WIDTH-1:0]  result vector from pe_cp32bit.
- Q_VALID  input  1  PECPOUT valid this cycle; single-cycle pulse per vector, no backpressure to the producer.
- DOUT  output  WIDTH  serial lane data.
- DOUT_VALID  output  1  DOUT holds a valid lane.
- DOUT_READY  input  1  consumer accepts DOUT this cycle.
- DOUT_LAST  output  1  DOUT is lane LANES-1 of the current vector.
- OVERFLOW  output  1  sticky: at least one vector dropped since reset.
- BUSY  output  1  buffer non-empty or a lane pending on DOUT.

Behaviour:
- Reset (RST=0 at a rising edge):
  - DOUT=0, DOUT_VALID=0, DOUT_LAST=0, OVERFLOW=0, BUSY=0.
  - Buffer pointers, occupancy count and lane index are cleared.
  - Any vector in flight is discarded. Reset mid-transfer truncates the stream; no LAST is emitted.
- Buffer:
  - Circular, DEPTH entries, write pointer and read pointer, occupancy count 0..DEPTH.
  - Q_VALID=1 and count<DEPTH: the full vector is written at the write pointer and the pointer advances, wrapping at DEPTH.
  - Q_VALID=1 and count==DEPTH with no pop this cycle: the vector is dropped, OVERFLOW is set, and buffer contents are unchanged.
  - Simultaneous push while full and a pop of the final lane: the slot freed this cycle is reused, the push is accepted, count is unchanged, and OVERFLOW is not set.
- Serialiser:
  - Lane index 0..LANES-1 selects a lane of the head entry.
  - DOUT, DOUT_VALID and DOUT_LAST are registered outputs.
  - A beat transfers when DOUT_VALID=1 and DOUT_READY=1.
  - DOUT_VALID=1 with DOUT_READY=0: DOUT, DOUT_VALID and DOUT_LAST hold stable.
  - On transfer of a non-last lane: the next lane is loaded in the following cycle.
  - On transfer of lane LANES-1 (DOUT_LAST=1): the head entry is popped, the lane index returns to 0, and lane 0 of the next entry is presented in the following cycle if count>0.
  - Streaming: back-to-back vectors with DOUT_READY held high produce LANES*k consecutive beats with no bubbles.
- Latency: Q_VALID at edge n into an empty, idle block gives DOUT_VALID=1 with lane 0 after edge n+1 (one cycle).
- Throughput: one lane per cycle; sustains one vector per LANES cycles, so Q_VALID pulses spaced >= LANES cycles never overflow with DOUT_READY=1.
- State machine:
  - IDLE: DOUT_VALID=0. Leaves when count>0, loading lane 0 and going to SEND.
  - SEND: DOUT_VALID=1. Advances the lane on each transfer. After the last-lane transfer it returns to IDLE if the buffer is empty after the pop, otherwise stays in SEND with lane 0 of the next entry.
- Data handling: no arithmetic on data; lanes are passed bit-exact. Lane index and pointers are sized $clog2(LANES) and $clog2(DEPTH); count is sized $clog2(DEPTH)+1.
- BUSY = (count!=0) | DOUT_VALID.

Test Plan:
- Single vector, READY=1:
  - Stimulus: after reset release, one Q_VALID pulse with lanes 0..7 = 0x1111_1111, 0x2222_2222, 0x3333_3333, 0x4444_4444, 0x5555_5555, 0x1234_1234, 0x5678_5678, 0x1234_5678 (upper 32 bits 0).
  - Response: 8 consecutive beats in that order starting one cycle after the pulse; DOUT_LAST only on 0x1234_5678; BUSY drops the cycle after; OVERFLOW=0.
- Backpressure:
  - Stimulus: same vector with DOUT_READY toggling 1,0,0,1,...
  - Response: DOUT is held stable while READY=0; exactly 8 beats are transferred in order with no duplicates.
- Back-to-back:
  - Stimulus: two pulses 8 cycles apart, data A then B, READY=1.
  - Response: 16 consecutive beats, A lanes then B lanes, with LAST on beats 8 and 16.
- Overflow:
  - Stimulus: READY=0; three pulses carrying A, B, C.
  - Response: OVERFLOW=1 after the third pulse. After READY=1, only A and B are emitted (16 beats); OVERFLOW stays 1.
- Full with simultaneous pop:
  - Stimulus: buffer holds A, B; the pulse for C coincides with the LAST-beat transfer of A.
  - Response: C is accepted, OVERFLOW=0, and the output order is A, B, C.
- Reset mid-stream:
  - Stimulus: RST=0 at the third beat of a vector.
  - Response: next cycle all outputs are 0 and the buffer is empty. A new pulse afterwards is streamed correctly from lane 0.
